// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding fetch_decode_reg.
//   Holds the fetch PC, issues word requests over req/gnt + rvalid, buffers
//   returned instructions in an in-order FIFO and presents the FIFO head to
//   decode. Redirects flush the FIFO and discard responses still in flight.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall_instruction           decode cannot accept; head is held
//   redirect_valid/redirect_pc  restart fetch at redirect_pc (bits [1:0] dropped)
//   imem_req/imem_addr          request and word address (= fetch PC)
//   imem_gnt                    request accepted this cycle
//   imem_rvalid/imem_rdata      in-order response
//   inst_encoding/pc/inst_valid FIFO head (NOP / fetch PC when empty)
// Optional feature macro: FETCH_PERF_EN adds perf_bubble_count[31:0], a
//   saturating count of out-of-reset cycles with inst_valid low.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter logic [31:0] NOP_ENCODING = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_encoding,
  output logic [31:0] pc,
  output logic        inst_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubble_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   fetch_pc, fetch_pc_d;
  logic [CW-1:0] outstanding, outstanding_d;
  logic [CW-1:0] drop_cnt, drop_cnt_d;
  logic [CW-1:0] fifo_count, fifo_count_d;
  logic [AW-1:0] fifo_rd, fifo_rd_d, fifo_wr, fifo_wr_d;
  logic [AW-1:0] pend_rd, pend_rd_d, pend_wr, pend_wr_d;

  logic [31:0] fifo_pc   [FIFO_DEPTH];
  logic [31:0] fifo_inst [FIFO_DEPTH];
  logic [31:0] pend_pc   [FIFO_DEPTH];

  logic credit_ok, issue, push, pop, drop_rsp;

  // Low address bits of a redirect target are forced to zero.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credits cover both buffered and in-flight instructions.
  assign credit_ok = (SW'(fifo_count) + SW'(outstanding)) < SW'(FIFO_DEPTH);
  assign imem_req  = rst_n && !redirect_valid && credit_ok;
  assign imem_addr = fetch_pc;

  assign issue    = imem_req && imem_gnt;
  assign drop_rsp = imem_rvalid && (drop_cnt != '0);
  assign push     = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
  assign pop      = inst_valid && !stall_instruction && !redirect_valid;

  assign inst_valid    = (fifo_count != '0);
  assign inst_encoding = inst_valid ? fifo_inst[fifo_rd] : NOP_ENCODING;
  assign pc            = inst_valid ? fifo_pc[fifo_rd] : fetch_pc;

  // Next-state for PC, counters and pointers; redirect overrides everything.
  always_comb begin
    fetch_pc_d    = fetch_pc;
    outstanding_d = outstanding + CW'(issue) - CW'(imem_rvalid);
    drop_cnt_d    = drop_cnt;
    fifo_count_d  = fifo_count;
    fifo_rd_d     = fifo_rd;
    fifo_wr_d     = fifo_wr;
    pend_rd_d     = pend_rd;
    pend_wr_d     = pend_wr;

    if (issue) begin
      pend_wr_d  = pend_wr + AW'(1);
      fetch_pc_d = fetch_pc + 32'd4;
    end
    // Every response retires one pending PC, whether kept or discarded.
    if (imem_rvalid) begin
      pend_rd_d = pend_rd + AW'(1);
    end

    if (redirect_valid) begin
      fetch_pc_d   = {redirect_pc[31:2], 2'b00};
      drop_cnt_d   = outstanding - CW'(imem_rvalid);
      fifo_count_d = '0;
      fifo_rd_d    = '0;
      fifo_wr_d    = '0;
    end else begin
      if (drop_rsp) drop_cnt_d = drop_cnt - CW'(1);
      if (push)     fifo_wr_d  = fifo_wr + AW'(1);
      if (pop)      fifo_rd_d  = fifo_rd + AW'(1);
      fifo_count_d = fifo_count + CW'(push) - CW'(pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      pend_rd     <= '0;
      pend_wr     <= '0;
    end else begin
      fetch_pc    <= fetch_pc_d;
      outstanding <= outstanding_d;
      drop_cnt    <= drop_cnt_d;
      fifo_count  <= fifo_count_d;
      fifo_rd     <= fifo_rd_d;
      fifo_wr     <= fifo_wr_d;
      pend_rd     <= pend_rd_d;
      pend_wr     <= pend_wr_d;
    end
  end

  // Storage arrays; contents are qualified by the counters so no reset needed.
  always_ff @(posedge clk) begin
    if (issue) pend_pc[pend_wr] <= fetch_pc;
    if (push) begin
      fifo_pc[fifo_wr]   <= pend_pc[pend_rd];
      fifo_inst[fifo_wr] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_count <= '0;
    end else if (!inst_valid && (perf_bubble_count != 32'hFFFF_FFFF)) begin
      perf_bubble_count <= perf_bubble_count + 32'd1;
    end
  end
`endif

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed bench for fetch_unit against a
// queue-based transaction model plus an in-order memory responder.
module tb_fetch_unit;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_instruction, redirect_valid, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst_encoding, pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubble_count;
  int          m_bubbles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [31:0] m_fpc;
  logic [31:0] m_pend[$];
  logic [31:0] m_fpcq[$];
  logic [31:0] m_fdat[$];
  int          m_drop;
  logic [31:0] mem_q[$];
  logic        exp_req, exp_valid;
  logic [31:0] exp_addr, exp_pc, exp_enc;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .stall_instruction(stall_instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_encoding(inst_encoding), .pc(pc), .inst_valid(inst_valid)
`ifdef FETCH_PERF_EN
    , .perf_bubble_count(perf_bubble_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void model_reset();
    m_fpc = 32'h0;
    m_pend.delete(); m_fpcq.delete(); m_fdat.delete(); mem_q.delete();
    m_drop = 0;
`ifdef FETCH_PERF_EN
    m_bubbles = 0;
`endif
  endfunction

  function automatic void model_outputs();
    exp_valid = (m_fpcq.size() > 0);
    exp_req   = rst_n && !redirect_valid && ((m_fpcq.size() + m_pend.size()) < DEPTH);
    exp_addr  = m_fpc;
    exp_pc    = exp_valid ? m_fpcq[0] : m_fpc;
    exp_enc   = exp_valid ? m_fdat[0] : NOP;
  endfunction

  // Advance the model by one clock using the inputs applied this cycle.
  function automatic void model_step();
    logic [31:0] p;
    logic        iss;
    iss = exp_req && imem_gnt;
`ifdef FETCH_PERF_EN
    if (!exp_valid) m_bubbles++;
`endif
    if (redirect_valid) begin
      if (imem_rvalid && m_pend.size() > 0) void'(m_pend.pop_front());
      m_drop = m_pend.size();
      m_fpcq.delete(); m_fdat.delete();
      m_fpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (m_fpcq.size() > 0 && !stall_instruction) begin
        void'(m_fpcq.pop_front()); void'(m_fdat.pop_front());
      end
      if (imem_rvalid && m_pend.size() > 0) begin
        p = m_pend.pop_front();
        if (m_drop > 0) m_drop--;
        else begin m_fpcq.push_back(p); m_fdat.push_back(mem_word(p)); end
      end
      if (iss) begin m_pend.push_back(m_fpc); m_fpc = m_fpc + 32'd4; end
    end
  endfunction

  // Apply inputs for the current cycle (called just after a falling edge).
  task automatic drive(input logic gnt, input logic stl, input logic rdv,
                       input logic [31:0] rpc, input logic allow_rsp);
    imem_gnt = gnt; stall_instruction = stl; redirect_valid = rdv; redirect_pc = rpc;
    if (allow_rsp && mem_q.size() > 0) begin
      imem_rvalid = 1'b1; imem_rdata = mem_word(mem_q[0]);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    model_outputs();
  endtask

  // Clock edge: memory responder observes the real request, model advances.
  task automatic tick();
    logic iss, rv;
    logic [31:0] ia;
    iss = imem_req && imem_gnt; ia = imem_addr; rv = imem_rvalid;
    @(posedge clk);
    model_step();
    if (rv && mem_q.size() > 0) void'(mem_q.pop_front());
    if (iss) mem_q.push_back(ia);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp += 5;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", imem_req); end
    if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    if (inst_encoding !== NOP) begin n_err++; $display("FAIL reset_enc got %h want %h", inst_encoding, NOP); end
    if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", pc); end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp += 3;
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL release_req got %b want 1", imem_req); end
    if (imem_addr !== 32'h0) begin n_err++; $display("FAIL release_addr got %h want 0", imem_addr); end
    if (inst_valid !== 1'b0 || inst_encoding !== NOP) begin
      n_err++; $display("FAIL release_head got v=%b e=%h want v=0 e=%h", inst_valid, inst_encoding, NOP);
    end
  endtask

  task automatic test_stream();
    logic [31:0] seq = 32'h0;
    for (int c = 0; c < 24; c++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp += 5;
      if (imem_req !== exp_req) begin n_err++; $display("FAIL stream_req c%0d got %b want %b", c, imem_req, exp_req); end
      if (imem_addr !== exp_addr) begin n_err++; $display("FAIL stream_addr c%0d got %h want %h", c, imem_addr, exp_addr); end
      if (inst_valid !== exp_valid) begin n_err++; $display("FAIL stream_valid c%0d got %b want %b", c, inst_valid, exp_valid); end
      if (pc !== exp_pc) begin n_err++; $display("FAIL stream_pc c%0d got %h want %h", c, pc, exp_pc); end
      if (inst_encoding !== exp_enc) begin n_err++; $display("FAIL stream_enc c%0d got %h want %h", c, inst_encoding, exp_enc); end
      if (c == 2) begin
        n_cmp++;
        if (inst_valid !== 1'b1 || pc !== 32'h0) begin
          n_err++; $display("FAIL stream_latency got v=%b pc=%h want v=1 pc=0", inst_valid, pc);
        end
      end
      if (inst_valid) begin
        n_cmp++;
        if (pc !== seq) begin n_err++; $display("FAIL stream_order c%0d got %h want %h", c, pc, seq); end
        seq = seq + 32'd4;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] hold_pc = 32'h0, hold_enc = 32'h0, seq = 32'h0;
    logic held = 1'b0, have_seq = 1'b0;
    for (int c = 0; c < 14; c++) begin
      logic stl;
      stl = (c >= 3 && c < 6);
      drive(1'b1, stl, 1'b0, 32'h0, 1'b1);
      n_cmp += 3;
      if (imem_req !== exp_req) begin n_err++; $display("FAIL stall_req c%0d got %b want %b", c, imem_req, exp_req); end
      if (pc !== exp_pc) begin n_err++; $display("FAIL stall_pc c%0d got %h want %h", c, pc, exp_pc); end
      if (inst_encoding !== exp_enc) begin n_err++; $display("FAIL stall_enc c%0d got %h want %h", c, inst_encoding, exp_enc); end
      if (stl && held) begin
        n_cmp++;
        if (pc !== hold_pc || inst_encoding !== hold_enc) begin
          n_err++; $display("FAIL stall_hold c%0d got %h/%h want %h/%h", c, pc, inst_encoding, hold_pc, hold_enc);
        end
      end
      if (stl && !held && inst_valid) begin held = 1'b1; hold_pc = pc; hold_enc = inst_encoding; end
      if (c == 5) begin
        n_cmp++;
        if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_credit got %b want 0", imem_req); end
      end
      if (inst_valid && !stl) begin
        if (have_seq) begin
          n_cmp++;
          if (pc !== seq) begin n_err++; $display("FAIL stall_order c%0d got %h want %h", c, pc, seq); end
        end
        seq = pc + 32'd4; have_seq = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    int k = 0;
    int w = 0;
    while (m_pend.size() < 2 && k < 10) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(); k++;
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    n_cmp++;
    if (m_pend.size() != 2 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL redir_setup got out=%0d v=%b want out=2 v=0", m_pend.size(), inst_valid);
    end
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    n_cmp++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_req got %b want 0", imem_req); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp += 2;
    if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush got %b want 0", inst_valid); end
    if (imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr got %h want 100", imem_addr); end
    while (!inst_valid && w < 20) begin
      n_cmp++;
      if (imem_req !== exp_req) begin n_err++; $display("FAIL redir_wait_req w%0d got %b want %b", w, imem_req, exp_req); end
      tick();
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      w++;
    end
    n_cmp += 2;
    if (pc !== 32'h100) begin n_err++; $display("FAIL redir_first_pc got %h want 100", pc); end
    if (inst_encoding !== mem_word(32'h100)) begin
      n_err++; $display("FAIL redir_first_enc got %h want %h", inst_encoding, mem_word(32'h100));
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    int got = 0;
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0;
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    tick();
    for (int c = 0; c < 30 && got < 3; c++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      if (inst_valid) begin
        n_cmp += 2;
        if (pc !== want[got]) begin n_err++; $display("FAIL wrap_pc %0d got %h want %h", got, pc, want[got]); end
        if (inst_encoding !== mem_word(want[got])) begin
          n_err++; $display("FAIL wrap_enc %0d got %h want %h", got, inst_encoding, mem_word(want[got]));
        end
        got++;
      end
      tick();
    end
    n_cmp++;
    if (got != 3) begin n_err++; $display("FAIL wrap_timeout got %0d want 3", got); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
    tick();
    while (m_pend.size() < 2 && k < 10) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      tick(); k++;
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 5;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL arst_req got %b want 0", imem_req); end
    if (imem_addr !== 32'h0) begin n_err++; $display("FAIL arst_addr got %h want 0", imem_addr); end
    if (inst_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", inst_valid); end
    if (inst_encoding !== NOP) begin n_err++; $display("FAIL arst_enc got %h want %h", inst_encoding, NOP); end
    if (pc !== 32'h0) begin n_err++; $display("FAIL arst_pc got %h want 0", pc); end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if (perf_bubble_count !== 32'h0) begin n_err++; $display("FAIL arst_perf got %0d want 0", perf_bubble_count); end
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] seq = 32'h0;
    logic [31:0] rpc;
    logic g, s, r, a;
    for (int c = 0; c < 400; c++) begin
      g = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) < 3);
      r = (c == 0) || ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 3) != 0);
      rpc = $urandom;
      drive(g, s, r, rpc, a);
      n_cmp += 5;
      if (imem_req !== exp_req) begin n_err++; $display("FAIL rand_req c%0d got %b want %b", c, imem_req, exp_req); end
      if (imem_addr !== exp_addr) begin n_err++; $display("FAIL rand_addr c%0d got %h want %h", c, imem_addr, exp_addr); end
      if (inst_valid !== exp_valid) begin n_err++; $display("FAIL rand_valid c%0d got %b want %b", c, inst_valid, exp_valid); end
      if (pc !== exp_pc) begin n_err++; $display("FAIL rand_pc c%0d got %h want %h", c, pc, exp_pc); end
      if (inst_encoding !== exp_enc) begin n_err++; $display("FAIL rand_enc c%0d got %h want %h", c, inst_encoding, exp_enc); end
      if (r) seq = {rpc[31:2], 2'b00};
      else if (inst_valid && !s) begin
        n_cmp++;
        if (pc !== seq) begin n_err++; $display("FAIL rand_order c%0d got %h want %h", c, pc, seq); end
        seq = seq + 32'd4;
      end
      tick();
    end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if (perf_bubble_count !== 32'(m_bubbles)) begin
      n_err++; $display("FAIL rand_perf got %0d want %0d", perf_bubble_count, m_bubbles);
    end
`endif
  endtask

  initial begin
    stall_instruction = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
